// File: rtl/num_formatter_pkg.sv
// Shared constants and FSM state type for the num_formatter binary-to-BCD display driver.
package num_formatter_pkg;

    localparam int unsigned DefBinW      = 37;
    localparam int unsigned DefNumDigits = 11;

    localparam int unsigned         GlyphW   = 4;
    localparam logic [GlyphW-1:0]   GlyphDot = 4'd10;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFmt,
        StCommit
    } state_e;

endpackage

// File: rtl/num_formatter_if.sv
// Value-in / glyphs-out bus of num_formatter. NUM_FMT_DP_EN adds the dp_pos decimal-point input.
interface num_formatter_if
    import num_formatter_pkg::*;
#(
    parameter int unsigned BIN_W      = DefBinW,
    parameter int unsigned NUM_DIGITS = DefNumDigits
);

    logic                         in_valid;
    logic                         in_ready;
    logic [BIN_W-1:0]             in_bin;
    logic [GlyphW*NUM_DIGITS-1:0] num_data;
    logic                         busy;
    logic                         done;
    logic                         ovf;
`ifdef NUM_FMT_DP_EN
    logic [3:0]                   dp_pos;

    modport master (
        output in_valid, in_bin, dp_pos,
        input  in_ready, num_data, busy, done, ovf
    );

    modport slave (
        input  in_valid, in_bin, dp_pos,
        output in_ready, num_data, busy, done, ovf
    );
`else
    modport master (
        output in_valid, in_bin,
        input  in_ready, num_data, busy, done, ovf
    );

    modport slave (
        input  in_valid, in_bin,
        output in_ready, num_data, busy, done, ovf
    );
`endif

endinterface

// File: rtl/num_formatter_bcd_adj3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added before the shift.
module num_formatter_bcd_adj3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/num_formatter.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) driving the glyph bus.
// Optional macro NUM_FMT_DP_EN adds a decimal point at position dp_pos.
module num_formatter
    import num_formatter_pkg::*;
#(
    parameter int unsigned BIN_W      = DefBinW,
    parameter int unsigned NUM_DIGITS = DefNumDigits
) (
    input logic            clk,
    input logic            rst_n,
    num_formatter_if.slave bus
);

    localparam int unsigned CntW = $clog2(BIN_W + 1);
    localparam int unsigned BcdW = GlyphW * NUM_DIGITS;

    state_e           state_q;
    logic [BIN_W-1:0] shreg_q;
    logic [BcdW-1:0]  bcd_q;
    logic [BcdW-1:0]  bcd_adj;
    logic [BcdW-1:0]  slot_vec;
    logic [BcdW-1:0]  glyph_d;
    logic [BcdW-1:0]  fmt_q;
    logic [BcdW-1:0]  num_data_q;
    logic [CntW-1:0]  cnt_q;
    logic             ovf_acc_q;
    logic             fmt_ovf_d;
    logic             fmt_ovf_q;
    logic             ovf_q;
    logic             done_q;
    logic             in_ready_q;
`ifdef NUM_FMT_DP_EN
    logic [3:0]       dp_q;
`endif

    // slot_vec is the BCD register in screen order: slot 0 = most significant digit.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        num_formatter_bcd_adj3 u_adj3 (
            .din  (bcd_q[g*GlyphW +: GlyphW]),
            .dout (bcd_adj[g*GlyphW +: GlyphW])
        );
        assign slot_vec[(NUM_DIGITS-1-g)*GlyphW +: GlyphW] = bcd_q[g*GlyphW +: GlyphW];
    end

    always_comb begin
        int dp_k;
        logic [BcdW-1:0] upper;
        dp_k      = 0;
        upper     = slot_vec >> GlyphW;
        glyph_d   = '0;
`ifdef NUM_FMT_DP_EN
        if (dp_q != 4'd0 && int'(dp_q) <= int'(NUM_DIGITS) - 2) dp_k = int'(dp_q);
`endif
        // With a dot the top slot is taken, so a nonzero top digit no longer fits.
        fmt_ovf_d = ovf_acc_q || (dp_k != 0 && bcd_q[BcdW-1 -: GlyphW] != '0);
        for (int s = 0; s < int'(NUM_DIGITS); s++) begin
            if (dp_k == 0 || s > int'(NUM_DIGITS) - 1 - dp_k) begin
                glyph_d[s*GlyphW +: GlyphW] = slot_vec[s*GlyphW +: GlyphW];
            end else if (s == int'(NUM_DIGITS) - 1 - dp_k) begin
                glyph_d[s*GlyphW +: GlyphW] = GlyphDot;
            end else begin
                glyph_d[s*GlyphW +: GlyphW] = upper[s*GlyphW +: GlyphW];
            end
        end
        if (fmt_ovf_d) glyph_d = {NUM_DIGITS{GlyphDot}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_acc_q  <= 1'b0;
            fmt_q      <= '0;
            fmt_ovf_q  <= 1'b0;
            num_data_q <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
`ifdef NUM_FMT_DP_EN
            dp_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid && in_ready_q) begin
                        shreg_q    <= bus.in_bin;
                        bcd_q      <= '0;
                        ovf_acc_q  <= 1'b0;
                        cnt_q      <= CntW'(BIN_W);
                        in_ready_q <= 1'b0;
`ifdef NUM_FMT_DP_EN
                        dp_q       <= bus.dp_pos;
`endif
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    bcd_q   <= {bcd_adj[BcdW-2:0], shreg_q[BIN_W-1]};
                    shreg_q <= shreg_q << 1;
                    if (bcd_adj[BcdW-1]) ovf_acc_q <= 1'b1;
                    cnt_q   <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) state_q <= StFmt;
                end
                StFmt: begin
                    fmt_q     <= glyph_d;
                    fmt_ovf_q <= fmt_ovf_d;
                    state_q   <= StCommit;
                end
                StCommit: begin
                    num_data_q <= fmt_q;
                    ovf_q      <= fmt_ovf_q;
                    done_q     <= 1'b1;
                    in_ready_q <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.busy     = ~in_ready_q;
    assign bus.done     = done_q;
    assign bus.ovf      = ovf_q;
    assign bus.num_data = num_data_q;

endmodule

// File: tb/tb_num_formatter.sv
// Randomised self-checking bench for num_formatter against a decimal-formatting reference model.
module tb_num_formatter;
    import num_formatter_pkg::*;

    localparam int unsigned BW = 37;
    localparam int unsigned ND = 11;
    localparam int unsigned NW = 4 * ND;

    logic          clk = 1'b0;
    logic          rst_n;
    int            n_checks = 0;
    int            n_errors = 0;
    logic [NW-1:0] exp_nd;
    logic          exp_ovf;

    num_formatter_if #(.BIN_W(BW), .NUM_DIGITS(ND)) bus ();

    num_formatter #(
        .BIN_W      (BW),
        .NUM_DIGITS (ND)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Decimal rendering straight from the display rules: slot 0 leftmost, LSD in slot ND-1.
    function automatic void model(input longint unsigned v, input int dp,
                                  output logic [NW-1:0] nd, output logic ov);
        int              k;
        int              cap;
        longint unsigned lim;
        longint unsigned rem;
        k   = (dp >= 1 && dp <= int'(ND) - 2) ? dp : 0;
        cap = (k != 0) ? int'(ND) - 1 : int'(ND);
        lim = 1;
        for (int i = 0; i < cap; i++) lim = lim * 10;
        ov  = (v >= lim);
        rem = v;
        nd  = '0;
        for (int s = int'(ND) - 1; s >= 0; s--) begin
            if (ov || (k != 0 && s == int'(ND) - 1 - k)) begin
                nd[4*s +: 4] = GlyphDot;
            end else begin
                nd[4*s +: 4] = 4'(rem % 10);
                rem = rem / 10;
            end
        end
    endfunction

    // Entered #1 after the accepting edge; returns #1 after the done edge.
    task automatic wait_done(input string tag, input logic [NW-1:0] nd, input logic ov);
        int lat;
        bit held;
        lat  = 0;
        held = 1'b1;
        while (!bus.done && lat < 80) begin
            if (bus.in_ready || bus.num_data != exp_nd || bus.ovf != exp_ovf) held = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ":hold"}, 64'(held), 64'd1);
        check({tag, ":latency"}, 64'(lat), 64'(BW + 2));
        check({tag, ":num_data"}, 64'(bus.num_data), 64'(nd));
        check({tag, ":ovf"}, 64'(bus.ovf), 64'(ov));
        check({tag, ":ready_busy"}, 64'({bus.in_ready, bus.busy}), 64'd2);
        exp_nd  = nd;
        exp_ovf = ov;
    endtask

    task automatic run_one(input string tag, input logic [BW-1:0] v, input logic [3:0] dp);
        logic [NW-1:0] nd;
        logic          ov;
        model(64'(v), int'(dp), nd, ov);
        bus.in_valid = 1'b1;
        bus.in_bin   = v;
`ifdef NUM_FMT_DP_EN
        bus.dp_pos   = dp;
`endif
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_done(tag, nd, ov);
        @(posedge clk);
        #1;
        check({tag, ":done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [NW-1:0] nd_a;
        logic [NW-1:0] nd_b;
        logic          ov_a;
        logic          ov_b;
        int            dones;

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bin   = '0;
`ifdef NUM_FMT_DP_EN
        bus.dp_pos   = '0;
`endif
        exp_nd  = '0;
        exp_ovf = 1'b0;
        #12;
        check("reset:num_data", 64'(bus.num_data), 64'd0);
        check("reset:ready_busy", 64'({bus.in_ready, bus.busy}), 64'd2);
        check("reset:done_ovf", 64'({bus.done, bus.ovf}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_one("d12345", BW'(64'd12345), 4'd0);
        check("d12345:literal", 64'(bus.num_data), 64'h543_2100_0000);
        run_one("all_nines", BW'(64'd99999999999), 4'd0);
        run_one("one_e11", BW'(64'd100000000000), 4'd0);
        check("one_e11:literal", 64'(bus.num_data), 64'hAAA_AAAA_AAAA);
        run_one("zero", BW'(64'd0), 4'd0);
        run_one("max", '1, 4'd0);

        // Back-to-back: valid stays high, B offered while A is converting.
        model(64'd7, 0, nd_a, ov_a);
        model(64'd42, 0, nd_b, ov_b);
        bus.in_valid = 1'b1;
        bus.in_bin   = BW'(64'd7);
        @(posedge clk);
        #1;
        bus.in_bin = BW'(64'd42);
        wait_done("b2b_a", nd_a, ov_a);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("b2b_b:accepted", 64'(bus.in_ready), 64'd0);
        check("b2b_b:shows_a", 64'(bus.num_data), 64'(nd_a));
        wait_done("b2b_b", nd_b, ov_b);
        @(posedge clk);
        #1;

        // Asynchronous reset 20 cycles into the shift phase.
        bus.in_valid = 1'b1;
        bus.in_bin   = BW'(64'd555);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst:num_data", 64'(bus.num_data), 64'd0);
        check("midrst:ready_busy", 64'({bus.in_ready, bus.busy}), 64'd2);
        check("midrst:done_ovf", 64'({bus.done, bus.ovf}), 64'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_nd  = '0;
        exp_ovf = 1'b0;
        dones   = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.done) dones++;
            @(posedge clk);
            #1;
        end
        check("midrst:no_done", 64'(dones), 64'd0);
        check("midrst:still_zero", 64'(bus.num_data), 64'd0);
        run_one("after_rst", BW'(64'd3), 4'd0);

`ifdef NUM_FMT_DP_EN
        run_one("dp_pi", BW'(64'd31415), 4'd4);
        check("dp_pi:literal", 64'(bus.num_data), 64'h514_1A30_0000);
        run_one("dp_1e10", BW'(64'd10000000000), 4'd4);
        run_one("dp_fit", BW'(64'd9999999999), 4'd4);
        run_one("dp_max_k", BW'(64'd123456789), 4'd9);
        run_one("dp_k10_as0", BW'(64'd98765432100), 4'd10);
        run_one("dp_k15_as0", BW'(64'd12345), 4'd15);
`endif

        for (int i = 0; i < 20; i++) begin
            logic [63:0]   r;
            logic [BW-1:0] v;
            logic [3:0]    dp;
            int            sel;
            r   = {$urandom, $urandom};
            sel = int'($urandom_range(0, 2));
            if (sel == 0) begin
                v = BW'($urandom_range(0, 999999));
            end else if (sel == 1) begin
                v = BW'(((i % 2 == 1) ? 64'd10000000000 : 64'd100000000000) - 64'd3
                        + 64'($urandom_range(0, 6)));
            end else begin
                v = r[BW-1:0];
            end
`ifdef NUM_FMT_DP_EN
            dp = 4'($urandom_range(0, 15));
`else
            dp = 4'd0;
`endif
            run_one("rand", v, dp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
